// File: rtl/counter_modulo_controller.sv
// Modulo counter with run/pause/done sequencing and a bounded wrap count.
// Optional macro COUNTER_CTRL_DOWN_EN adds a 'down' input selecting down-counting runs.
module counter_modulo_controller #(
    parameter int WIDTH  = 3,
    parameter int CWIDTH = 4
) (
    input  logic              clockpulse,
    input  logic              clear,
    input  logic              start,
    input  logic              stop,
    input  logic              hold,
    input  logic [WIDTH-1:0]  terminal,
    input  logic [CWIDTH-1:0] cycles,
`ifdef COUNTER_CTRL_DOWN_EN
    input  logic              down,
`endif
    output logic [WIDTH-1:0]  signal_q,
    output logic [WIDTH-1:0]  signal_q_,
    output logic [1:0]        state,
    output logic              busy,
    output logic              wrap,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t            cur_state, nxt_state;
    logic [WIDTH-1:0]  count_r, count_nxt;
    logic [WIDTH-1:0]  term_r, term_nxt;
    logic [CWIDTH-1:0] cyc_r, cyc_nxt;
    logic [CWIDTH-1:0] wraps_r, wraps_nxt, wraps_inc;
    logic              down_r, down_nxt, down_in;
    logic              wrap_nxt, done_nxt;
    logic              at_end;
    logic [WIDTH-1:0]  reload, stepped;

`ifdef COUNTER_CTRL_DOWN_EN
    assign down_in = down;
`else
    assign down_in = 1'b0;
`endif

    // Wrap point and reload value depend on the direction latched at start.
    always_comb begin
        at_end    = down_r ? (count_r == '0) : (count_r == term_r);
        reload    = down_r ? term_r : '0;
        stepped   = down_r ? (count_r - 1'b1) : (count_r + 1'b1);
        wraps_inc = (wraps_r == '1) ? wraps_r : (wraps_r + 1'b1);
    end

    always_comb begin
        nxt_state = cur_state;
        count_nxt = count_r;
        term_nxt  = term_r;
        cyc_nxt   = cyc_r;
        wraps_nxt = wraps_r;
        down_nxt  = down_r;
        wrap_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (cur_state)
            IDLE: begin
                count_nxt = '0;
                if (start) begin
                    term_nxt  = terminal;
                    cyc_nxt   = cycles;
                    down_nxt  = down_in;
                    wraps_nxt = '0;
                    count_nxt = down_in ? terminal : '0;
                    nxt_state = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    nxt_state = IDLE;
                    count_nxt = '0;
                end else if (hold) begin
                    nxt_state = PAUSE;
                end else if (at_end) begin
                    count_nxt = reload;
                    wrap_nxt  = 1'b1;
                    wraps_nxt = wraps_inc;
                    if (cyc_r != '0 && wraps_inc == cyc_r) begin
                        nxt_state = DONE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    count_nxt = stepped;
                end
            end
            PAUSE: begin
                if (stop) begin
                    nxt_state = IDLE;
                    count_nxt = '0;
                end else if (!hold) begin
                    nxt_state = RUN;
                end
            end
            DONE: begin
                nxt_state = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clockpulse) begin
        if (clear) begin
            cur_state <= IDLE;
            count_r   <= '0;
            term_r    <= '0;
            cyc_r     <= '0;
            wraps_r   <= '0;
            down_r    <= 1'b0;
            wrap      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            count_r   <= count_nxt;
            term_r    <= term_nxt;
            cyc_r     <= cyc_nxt;
            wraps_r   <= wraps_nxt;
            down_r    <= down_nxt;
            wrap      <= wrap_nxt;
            done      <= done_nxt;
        end
    end

    assign signal_q  = count_r;
    assign signal_q_ = ~count_r;
    assign state     = cur_state;
    assign busy      = (cur_state == RUN) || (cur_state == PAUSE);

endmodule

// File: tb/tb_counter_modulo_controller.sv
// Bench for counter_modulo_controller: arithmetic reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_counter_modulo_controller;

    localparam int W    = 3;
    localparam int CW   = 4;
    localparam int MAXQ = (1 << W) - 1;
    localparam int MAXC = (1 << CW) - 1;

    logic          clockpulse = 1'b0;
    logic          clear = 1'b1, start = 1'b0, stop = 1'b0, hold = 1'b0, down = 1'b0;
    logic [W-1:0]  terminal = '0;
    logic [CW-1:0] cycles = '0;
    logic [W-1:0]  signal_q, signal_q_;
    logic [1:0]    state;
    logic          busy, wrap, done;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model: mode 0=idle 1=run 2=pause 3=done
    int ms = 0, mq = 0, mterm = 0, mcyc = 0, mwraps = 0, mdown = 0, mwrap = 0, mdone = 0;

    counter_modulo_controller #(.WIDTH(W), .CWIDTH(CW)) dut (
        .clockpulse (clockpulse),
        .clear      (clear),
        .start      (start),
        .stop       (stop),
        .hold       (hold),
        .terminal   (terminal),
        .cycles     (cycles),
`ifdef COUNTER_CTRL_DOWN_EN
        .down       (down),
`endif
        .signal_q   (signal_q),
        .signal_q_  (signal_q_),
        .state      (state),
        .busy       (busy),
        .wrap       (wrap),
        .done       (done)
    );

    always #5 clockpulse = ~clockpulse;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // Counting is arithmetic modulo (terminal+1); a wrap is the step that lands on the reload value.
    always @(posedge clockpulse) begin
        mwrap = 0;
        mdone = 0;
        if (clear) begin
            ms = 0; mq = 0; mterm = 0; mcyc = 0; mwraps = 0; mdown = 0;
        end else begin
            case (ms)
                0: begin
                    mq = 0;
                    if (start) begin
                        ms = 1; mterm = terminal; mcyc = cycles; mwraps = 0;
`ifdef COUNTER_CTRL_DOWN_EN
                        mdown = down;
`else
                        mdown = 0;
`endif
                        mq = mdown ? mterm : 0;
                    end
                end
                1: begin
                    if (stop) begin
                        ms = 0; mq = 0;
                    end else if (hold) begin
                        ms = 2;
                    end else begin
                        mwrap = mdown ? (mq == 0) : (mq == mterm);
                        mq = mdown ? (mq + mterm) % (mterm + 1) : (mq + 1) % (mterm + 1);
                        if (mwrap) begin
                            mwraps = (mwraps + 1 > MAXC) ? MAXC : mwraps + 1;
                            if (mcyc != 0 && mwraps == mcyc) begin
                                ms = 3; mdone = 1;
                            end
                        end
                    end
                end
                2: begin
                    if (stop) begin
                        ms = 0; mq = 0;
                    end else if (!hold) ms = 1;
                end
                default: begin
                    ms = 0; mq = 0;
                end
            endcase
        end
    end

    always @(negedge clockpulse) begin
        if (chk_en) begin
            chk("m_state", state, ms);
            chk("m_q", signal_q, mq);
            chk("m_qn", signal_q_, MAXQ - mq);
            chk("m_busy", busy, (ms == 1 || ms == 2));
            chk("m_wrap", wrap, mwrap);
            chk("m_done", done, mdone);
        end
    end

    task automatic step();
        @(posedge clockpulse);
        @(negedge clockpulse);
    endtask

    task automatic begin_run(input int t, input int c);
        terminal = W'(t);
        cycles   = CW'(c);
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    initial begin
        // Reset for two cycles, then idle
        clear = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        clear = 1'b0;
        step();
        chk("rst_state", state, 0);
        chk("rst_q", signal_q, 0);
        chk("rst_qn", signal_q_, 7);
        chk("rst_busy", busy, 0);

        // Two full wraps of 0..7, done on the 16th edge
        begin_run(7, 2);
        chk("r32_state", state, 1);
        chk("r32_q0", signal_q, 0);
        for (int i = 1; i < 16; i++) begin
            step();
            chk("r32_q", signal_q, i % 8);
            chk("r32_wrap", wrap, (i == 8));
            chk("r32_done", done, 0);
        end
        step();
        chk("r32_done16", done, 1);
        chk("r32_wrap16", wrap, 1);
        chk("r32_st16", state, 3);
        step();
        chk("r32_idle", state, 0);

        // Hold at 2 for three cycles, resume, then stop
        begin_run(4, 0);
        step(); step();
        chk("r33_q2", signal_q, 2);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("r33_pause", state, 2);
            chk("r33_frozen", signal_q, 2);
        end
        hold = 1'b0;
        step();
        chk("r33_resume", state, 1);
        chk("r33_q_hold", signal_q, 2);
        step(); chk("r33_q3", signal_q, 3);
        step(); chk("r33_q4", signal_q, 4);
        step(); chk("r33_q0", signal_q, 0); chk("r33_wrap", wrap, 1);
        step(); chk("r33_q1", signal_q, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("r33_stop_st", state, 0);
        chk("r33_stop_q", signal_q, 0);
        chk("r33_stop_done", done, 0);

        // Terminal 0: three consecutive wraps, done on the third
        begin_run(0, 3);
        chk("r34_w0", wrap, 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("r34_q", signal_q, 0);
            chk("r34_wrap", wrap, 1);
            chk("r34_done", done, (i == 3));
        end

        // Start during DONE is ignored
        step();
        begin_run(0, 1);
        step();
        chk("r35_in_done", state, 3);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("r35_start_ign", state, 0);

        // Clear with stop and hold mid-run
        begin_run(7, 0);
        step(); step();
        clear = 1'b1; stop = 1'b1; hold = 1'b1;
        step();
        clear = 1'b0; stop = 1'b0; hold = 1'b0;
        chk("r35_clr_st", state, 0);
        chk("r35_clr_q", signal_q, 0);
        chk("r35_clr_qn", signal_q_, 7);
        chk("r35_clr_busy", busy, 0);
        chk("r35_clr_wrap", wrap, 0);
        chk("r35_clr_done", done, 0);

`ifdef COUNTER_CTRL_DOWN_EN
        down = 1'b1;
        begin_run(5, 1);
        down = 1'b0;
        chk("r36_q5", signal_q, 5);
        for (int i = 4; i >= 0; i--) begin
            step();
            chk("r36_q", signal_q, i);
            chk("r36_wrap_lo", wrap, 0);
        end
        step();
        chk("r36_wrap", wrap, 1);
        chk("r36_done", done, 1);
        step();
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            clear    = ($urandom_range(0, 99) == 0);
            start    = ($urandom_range(0, 3) == 0);
            stop     = ($urandom_range(0, 39) == 0);
            hold     = ($urandom_range(0, 5) == 0);
            terminal = W'($urandom);
            cycles   = ($urandom_range(0, 7) == 0) ? CW'($urandom) : CW'($urandom_range(0, 3));
            down     = 1'(($urandom));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
